traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/sec_tick_detect.sv | 21 ++
 rtl/traffic_light_ctrl.sv | 126 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, light and count definitions for the traffic light controller
package traffic_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED1   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED2   = 3'd5
    } tl_state_t;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    // {main, side} lamp pattern; any state not listed shows red on both roads
    function automatic logic [5:0] lights_for(tl_state_t s);
        logic [5:0] l;
        l = {LIGHT_R, LIGHT_R};
        case (s)
            MAIN_G:  l = {LIGHT_G, LIGHT_R};
            MAIN_Y:  l = {LIGHT_Y, LIGHT_R};
            SIDE_G:  l = {LIGHT_R, LIGHT_G};
            SIDE_Y:  l = {LIGHT_R, LIGHT_Y};
            default: l = {LIGHT_R, LIGHT_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// rtl/sec_tick_detect.sv - one-clk tick on each rising edge of the seconds strobe
module sec_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic sec_clk,
    output logic tick
);

    logic sec_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_prev_q <= 1'b0;
        end else begin
            sec_prev_q <= sec_clk;
        end
    end

    assign tick = sec_clk & ~sec_prev_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road traffic light sequencer; TL_PED_REQ_EN adds pedestrian-shortened main green
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MAIN_S = 30,
    parameter int GREEN_SIDE_S = 20,
    parameter int YELLOW_S     = 3,
    parameter int ALLRED_S     = 1,
    parameter int PED_MIN_S    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_clk,
`ifdef TL_PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic [CNT_W-1:0] count_s,
    output logic [2:0]       state_o
);

    if ((GREEN_MAIN_S < 1) || (GREEN_MAIN_S > 99) ||
        (GREEN_SIDE_S < 1) || (GREEN_SIDE_S > 99) ||
        (YELLOW_S     < 1) || (YELLOW_S     > 99) ||
        (ALLRED_S     < 1) || (ALLRED_S     > 99) ||
        (PED_MIN_S    < 1) || (PED_MIN_S    > 99)) begin : g_bad_duration
        $error("traffic_light_ctrl: every duration must lie in 1..99");
    end

    localparam logic [CNT_W-1:0] DUR_GM  = CNT_W'(GREEN_MAIN_S);
    localparam logic [CNT_W-1:0] DUR_GS  = CNT_W'(GREEN_SIDE_S);
    localparam logic [CNT_W-1:0] DUR_Y   = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] DUR_AR  = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] dur_of(tl_state_t s);
        logic [CNT_W-1:0] d;
        d = DUR_AR;
        case (s)
            MAIN_G:         d = DUR_GM;
            MAIN_Y, SIDE_Y: d = DUR_Y;
            SIDE_G:         d = DUR_GS;
            default:        d = DUR_AR;
        endcase
        return d;
    endfunction

    logic             tick;
    tl_state_t        state_q;
    tl_state_t        next_state_d;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       main_light_q;
    logic [2:0]       side_light_q;
    logic             shorten;
    logic             last_sec;

    sec_tick_detect u_tick (
        .clk     (clk),
        .reset   (reset),
        .sec_clk (sec_clk),
        .tick    (tick)
    );

    always_comb begin
        next_state_d = MAIN_G;
        case (state_q)
            MAIN_G:  next_state_d = MAIN_Y;
            MAIN_Y:  next_state_d = RED1;
            RED1:    next_state_d = SIDE_G;
            SIDE_G:  next_state_d = SIDE_Y;
            SIDE_Y:  next_state_d = RED2;
            default: next_state_d = MAIN_G;
        endcase
    end

    assign last_sec = (count_q <= CNT_ONE);

`ifdef TL_PED_REQ_EN
    localparam logic [CNT_W-1:0] DUR_PM = CNT_W'(PED_MIN_S);

    logic ped_pending_q;

    // A press that coincides with side-green entry is kept rather than lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pending_q <= 1'b0;
        end else if (ped_req) begin
            ped_pending_q <= 1'b1;
        end else if (tick && last_sec && (state_q == RED1)) begin
            ped_pending_q <= 1'b0;
        end
    end

    assign shorten = (state_q == MAIN_G) && ped_pending_q && (count_q > DUR_PM);
`else
    assign shorten = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RED2;
            count_q      <= DUR_AR;
            main_light_q <= LIGHT_R;
            side_light_q <= LIGHT_R;
        end else if (tick) begin
            if (shorten) begin
`ifdef TL_PED_REQ_EN
                count_q <= DUR_PM;
`endif
            end else if (!last_sec) begin
                count_q <= count_q - CNT_ONE;
            end else begin
                state_q                      <= next_state_d;
                count_q                      <= dur_of(next_state_d);
                {main_light_q, side_light_q} <= lights_for(next_state_d);
            end
        end
    end

    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign count_s    = count_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - scoreboard bench for traffic_light_ctrl against a table-driven timing model
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int GM = 8;
    localparam int GS = 3;
    localparam int YL = 2;
    localparam int AR = 1;
    localparam int PM = 5;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] cnt;
        logic [2:0] ml;
        logic [2:0] sl;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_clk = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [7:0] count_s;
    logic [2:0] state_o;
`ifdef TL_PED_REQ_EN
    logic       ped_req = 1'b0;
`endif

    traffic_light_ctrl #(
        .GREEN_MAIN_S (GM),
        .GREEN_SIDE_S (GS),
        .YELLOW_S     (YL),
        .ALLRED_S     (AR),
        .PED_MIN_S    (PM)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .sec_clk    (sec_clk),
`ifdef TL_PED_REQ_EN
        .ped_req    (ped_req),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .count_s    (count_s),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    obs_t exp_q[$];

    // Cycle order: MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2
    tl_state_t  state_tab[6] = '{MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2};
    int         dur_tab[6]   = '{GM, YL, AR, GS, YL, AR};
    logic [2:0] main_tab[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_idx;
    int m_cnt;
    bit m_ped;

    function automatic obs_t model_obs();
        obs_t o;
        o.st  = state_tab[m_idx];
        o.cnt = 8'(m_cnt);
        o.ml  = main_tab[m_idx];
        o.sl  = side_tab[m_idx];
        return o;
    endfunction

    task automatic model_reset();
        m_idx = 5;
        m_cnt = AR;
        m_ped = 1'b0;
    endtask

    task automatic model_tick();
        if (m_idx == 0 && m_ped && m_cnt > PM) begin
            m_cnt = PM;
        end else if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
        end else begin
            m_idx = (m_idx + 1) % 6;
            m_cnt = dur_tab[m_idx];
            if (m_idx == 3) m_ped = 1'b0;
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic check_now(input string name, input obs_t want);
        obs_t got;
        got = {state_o, count_s, main_light, side_light};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got st=%0d cnt=%0d main=%b side=%b, want st=%0d cnt=%0d main=%b side=%b",
                     name, got.st, got.cnt, got.ml, got.sl, want.st, want.cnt, want.ml, want.sl);
        end
    endtask

    task automatic ped_pulse();
`ifdef TL_PED_REQ_EN
        @(posedge clk);
        #1 ped_req = 1'b1;
        @(posedge clk);
        m_ped = 1'b1;
        #1 ped_req = 1'b0;
`endif
    endtask

    // One seconds strobe: high for hi clks, then low for lo clks
    task automatic send_sec(input int hi, input int lo);
        @(posedge clk);
        #1 sec_clk = 1'b1;
        model_tick();
        repeat (hi) @(posedge clk);
        #1 sec_clk = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    obs_t prev;
    always @(negedge clk) begin
        obs_t cur;
        obs_t want;
        cur = {state_o, count_s, main_light, side_light};
        if (rst_n) begin
            vectors++;
            if (main_light != 3'b100 && side_light != 3'b100) begin
                miscompares++;
                $display("FAIL safety: main=%b side=%b, want at least one road red", main_light, side_light);
            end
            if (cur !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change: got st=%0d cnt=%0d, want no change", cur.st, cur.cnt);
                end else begin
                    want = exp_q.pop_front();
                    if (cur !== want) begin
                        miscompares++;
                        $display("FAIL tick_step: got st=%0d cnt=%0d main=%b side=%b, want st=%0d cnt=%0d main=%b side=%b",
                                 cur.st, cur.cnt, cur.ml, cur.sl, want.st, want.cnt, want.ml, want.sl);
                    end
                end
            end
        end
        prev = cur;
    end

    initial begin
        int guard;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_now("reset_state", model_obs());
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_now("post_release_hold", model_obs());

        for (int i = 0; i < 10; i++) send_sec(1, 2);
        send_sec(100, 3);

        guard = 0;
        while (!(m_idx == 4 && m_cnt == 2) && guard < 60) begin
            send_sec($urandom_range(1, 3), $urandom_range(0, 3));
            guard++;
        end
        vectors++;
        if (!(m_idx == 4 && m_cnt == 2)) begin
            miscompares++;
            $display("FAIL seek_side_y: got idx=%0d cnt=%0d, want idx=4 cnt=2", m_idx, m_cnt);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_now("async_reset_mid_side_y", model_obs());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef TL_PED_REQ_EN
        guard = 0;
        while (!(m_idx == 0 && m_cnt == PM + 2) && guard < 40) begin
            send_sec(1, 1);
            guard++;
        end
        ped_pulse();
        send_sec(1, 1);
        vectors++;
        if (m_cnt != PM) begin
            miscompares++;
            $display("FAIL ped_shorten_model: got %0d, want %0d", m_cnt, PM);
        end
        guard = 0;
        while (!(m_idx == 0 && m_cnt == 3) && guard < 40) begin
            send_sec(1, 1);
            guard++;
        end
        ped_pulse();
        for (int i = 0; i < 3; i++) send_sec(1, 1);
`endif

        for (int i = 0; i < 60; i++) begin
            send_sec($urandom_range(1, 4), $urandom_range(0, 4));
            if (m_idx == 0 && $urandom_range(0, 5) == 0) ped_pulse();
        end

        repeat (5) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
